// File: rtl/slave_port_pkg.sv
// Shared types and constants for the serial slave endpoint.
// Holds the transaction FSM encoding and the header length derived from the field widths.
package slave_port_pkg;

  localparam int ADDR_LEN_DEF  = 12;
  localparam int DATA_LEN_DEF  = 8;
  localparam int BURST_LEN_DEF = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_WDATA,
    S_WRITE,
    S_RREQ,
    S_RWAIT,
    S_RDATA,
    S_DONE
  } state_e;

  function automatic int hdr_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Header beats carry address and burst side by side; the longer field sets the length.
  localparam int HDR = hdr_len(ADDR_LEN_DEF, BURST_LEN_DEF);

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register used for every serial field: parallel load, LSB-first
// shift-in at the MSB end, or shift-out towards bit 0 with zero fill.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_in_en,
  input  logic         shift_in_bit,
  input  logic         shift_out_en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_in_en) begin
      q <= {shift_in_bit, q[W-1:1]};
    end else if (shift_out_en) begin
      q <= {1'b0, q[W-1:1]};
    end
  end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave: deserialises header and write data, performs word writes/reads
// on a single-port memory and serialises read data back, LSB first.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_LEN  = ADDR_LEN_DEF,
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slave_select,
  input  logic                master_valid,
  input  logic                rx_address,
  input  logic                rx_burst_number,
  input  logic                rx_data,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                master_ready,
  output logic                slave_ready,
  output logic                slave_valid,
  output logic                tx_data,
  output logic                rx_done,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  localparam int HDR_BEATS = hdr_len(ADDR_LEN, BURST_LEN);
  localparam int CNT_W     = $clog2(hdr_len(HDR_BEATS, DATA_LEN) + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BEATS - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_LEN - 1);

  // Handshake: a serial bit moves only on a beat, i.e. when slave_select,
  // master_valid and slave_ready are all high at the same rising edge; read bits
  // move when slave_valid and master_ready are both high at the edge.
  state_e                 state, state_d;
  logic [CNT_W-1:0]       bit_cnt, cnt_d;
  logic                   is_write;
  logic [ADDR_LEN-1:0]    addr_q;
  logic [BURST_LEN-1:0]   burst_q, burst_after;
  logic [DATA_LEN-1:0]    wdata_q, rdata_q;
  logic beat, valid_start, hdr_beat, addr_shift, burst_shift;
  logic rd_accept, word_done_r, step_word;

  assign slave_ready = reset && slave_select &&
                       (state == S_IDLE || state == S_HEADER || state == S_WDATA);
  assign slave_valid = slave_select && (state == S_RDATA);
  assign tx_data     = slave_valid && rdata_q[0];
  assign mem_we      = slave_select && (state == S_WRITE);
  assign rx_done     = slave_select && (state == S_DONE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  assign beat        = slave_select && master_valid && slave_ready;
  assign valid_start = (state == S_IDLE) && beat && (write_en ^ read_en);
  assign hdr_beat    = (state == S_HEADER) && beat;
  assign addr_shift  = valid_start || (hdr_beat && bit_cnt < CNT_W'(ADDR_LEN));
  assign burst_shift = valid_start || (hdr_beat && bit_cnt < CNT_W'(BURST_LEN));
  // Zero-burst decision must see the bit arriving on the final header beat.
  assign burst_after = burst_shift ? {rx_burst_number, burst_q[BURST_LEN-1:1]} : burst_q;
  assign rd_accept   = slave_valid && master_ready;
  assign word_done_r = rd_accept && (bit_cnt == WORD_LAST);
  assign step_word   = mem_we || word_done_r;

  serial_shift_reg #(.W(ADDR_LEN)) u_addr (
    .clk(clk), .reset(reset),
    .load(step_word), .load_data(addr_q + ADDR_LEN'(1)),
    .shift_in_en(addr_shift), .shift_in_bit(rx_address),
    .shift_out_en(1'b0), .q(addr_q)
  );

  serial_shift_reg #(.W(BURST_LEN)) u_burst (
    .clk(clk), .reset(reset),
    .load(step_word), .load_data(burst_q - BURST_LEN'(1)),
    .shift_in_en(burst_shift), .shift_in_bit(rx_burst_number),
    .shift_out_en(1'b0), .q(burst_q)
  );

  serial_shift_reg #(.W(DATA_LEN)) u_wdata (
    .clk(clk), .reset(reset),
    .load(1'b0), .load_data('0),
    .shift_in_en((state == S_WDATA) && beat), .shift_in_bit(rx_data),
    .shift_out_en(1'b0), .q(wdata_q)
  );

  serial_shift_reg #(.W(DATA_LEN)) u_rdata (
    .clk(clk), .reset(reset),
    .load(slave_select && (state == S_RWAIT)), .load_data(mem_rdata),
    .shift_in_en(1'b0), .shift_in_bit(1'b0),
    .shift_out_en(rd_accept), .q(rdata_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      is_write <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= cnt_d;
      if (valid_start) is_write <= write_en;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = bit_cnt;
    if (!slave_select && state != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (valid_start) begin
            state_d = S_HEADER;
            cnt_d   = CNT_W'(1);
          end
        end
        S_HEADER: begin
          if (beat) begin
            if (bit_cnt == HDR_LAST) begin
              cnt_d = '0;
              if (burst_after == '0) state_d = S_DONE;
              else if (is_write)     state_d = S_WDATA;
              else                   state_d = S_RREQ;
            end else begin
              cnt_d = bit_cnt + CNT_W'(1);
            end
          end
        end
        S_WDATA: begin
          if (beat) begin
            if (bit_cnt == WORD_LAST) begin
              cnt_d   = '0;
              state_d = S_WRITE;
            end else begin
              cnt_d = bit_cnt + CNT_W'(1);
            end
          end
        end
        S_WRITE: state_d = (burst_q == BURST_LEN'(1)) ? S_DONE : S_WDATA;
        S_RREQ:  state_d = S_RWAIT;
        S_RWAIT: state_d = S_RDATA;
        S_RDATA: begin
          if (rd_accept) begin
            if (bit_cnt == WORD_LAST) begin
              cnt_d   = '0;
              state_d = (burst_q == BURST_LEN'(1)) ? S_DONE : S_RREQ;
            end else begin
              cnt_d = bit_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
